hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: id_rs1, id_rs2  in  5 each  ID-stage source registers; id_use_rs1, id_use_rs2  in  1 each  source actually read.
REQ-004 SHALL have ports: id_branch, id_jump  in  1 each  ID holds conditional branch / jalr; both resolve in ID.
REQ-005 SHALL have ports: id_redirect  in  1  ID resolved taken branch/jump.
REQ-006 SHALL have ports: ex_rd  in  5; ex_reg_we  in  1; ex_mem_read  in  1  EX-stage load; mem_rd  in  5; mem_mem_read  in  1  MEM-stage load.
REQ-007 SHALL have ports: ex_md_start  in  1  multi-cycle mul/div entered EX; md_done  in  1  result valid.
REQ-008 SHALL have ports: dbg_halt_req  in  1  level halt request; halted  out  1  pipeline frozen.
REQ-009 SHALL have ports: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush  out  1 each  pipeline controls.
REQ-010 SHALL have ports: fsm_state  out  2  RUN=0, BR_LOAD=1, MD_WAIT=2, HALT=3.

Function
REQ-011 SHALL define match(r) = r!=0 && ((id_use_rs1 && r==id_rs1) || (id_use_rs2 && r==id_rs2)); x0 SHALL never cause a hazard.
REQ-012 SHALL define load_use = ex_mem_read && match(ex_rd).
REQ-013 SHALL define br = id_branch || id_jump; br_alu = br && ex_reg_we && !ex_mem_read && match(ex_rd); br_mload = br && mem_mem_read && match(mem_rd).
REQ-014 SHALL define STALL as pc_stall=1, if_id_stall=1, id_ex_flush=1; FREEZE as pc_stall=1, if_id_stall=1, id_ex_stall=1, ex_mem_flush=1; unlisted outputs 0.
REQ-015 RUN SHALL apply the first true row, priority top-down: ex_md_start && !md_done -> FREEZE, go MD_WAIT; load_use && br -> STALL, go BR_LOAD; load_use -> STALL, stay; br_alu || br_mload -> STALL, stay; dbg_halt_req -> no control asserted, go HALT; id_redirect -> if_id_flush=1; else all 0.
REQ-016 id_redirect SHALL be ignored in any cycle in which any stall or FREEZE is asserted.
REQ-017 BR_LOAD SHALL assert STALL for exactly one cycle and return to RUN unconditionally; total branch-after-load penalty = 2 cycles.
REQ-018 MD_WAIT SHALL assert FREEZE while md_done=0; in the md_done=1 cycle it SHALL assert nothing and go RUN.
REQ-019 ex_md_start && md_done in the same RUN cycle SHALL cause no freeze.
REQ-020 HALT SHALL assert FREEZE and halted=1; on dbg_halt_req=0 it SHALL go RUN, and halted SHALL be 0 from the next cycle.
REQ-021 dbg_halt_req in BR_LOAD or MD_WAIT SHALL be deferred until RUN.
REQ-022 fsm_state SHALL equal the registered state; all other outputs are combinational in state and inputs.

Reset
REQ-023 rst=1 at an edge SHALL force state RUN; every output SHALL read 0 while rst=1; reset in any state, including mid-MD_WAIT or HALT, SHALL abandon that state.

Configuration
REQ-024 With HAZARD_STALL_CNT_EN defined, out port stall_cycles [31:0] SHALL exist; it SHALL increment on every edge where pc_stall=1, saturate at 32'hFFFF_FFFF, and reset to 0.
REQ-025 Without HAZARD_STALL_CNT_EN, stall_cycles and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, no br -> one STALL cycle, state stays 0.
REQ-027 Same as REQ-026 plus id_branch=1 -> STALL 2 cycles, fsm_state 0->1->0, id_redirect=1 ignored during both.
REQ-028 ex_md_start=1, md_done rising 4 cycles later -> FREEZE 4 cycles, then 0, fsm_state 2 during freeze.
REQ-029 dbg_halt_req=1 in RUN, held 3 cycles -> halted=1 from the next cycle, FREEZE while held; 0 one cycle after release.
REQ-030 ex_rd=0, ex_mem_read=1, id_rs1=0, id_use_rs1=1 -> no stall; rst=1 in MD_WAIT -> state 0, outputs 0; with macro, 6 stall cycles -> stall_cycles=6.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard inputs, debug halt and pipeline control outputs.
// Optional: HAZARD_STALL_CNT_EN adds the stall_cycles counter output.
interface hazard_ctrl_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned CNT_W = 32;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_branch;
    logic             id_jump;
    logic             id_redirect;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_we;
    logic             ex_mem_read;
    logic [REG_W-1:0] mem_rd;
    logic             mem_mem_read;
    logic             ex_md_start;
    logic             md_done;
    logic             dbg_halt_req;
    logic             halted;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [ST_W-1:0]  fsm_state;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_jump, id_redirect,
               ex_rd, ex_reg_we, ex_mem_read, mem_rd, mem_mem_read,
               ex_md_start, md_done, dbg_halt_req,
        output halted, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_flush, fsm_state
`ifdef HAZARD_STALL_CNT_EN
        , output stall_cycles
`endif
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_jump, id_redirect,
               ex_rd, ex_reg_we, ex_mem_read, mem_rd, mem_mem_read,
               ex_md_start, md_done, dbg_halt_req,
        input  halted, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_flush, fsm_state
`ifdef HAZARD_STALL_CNT_EN
        , input stall_cycles
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, mul/div freeze, debug halt.
// Optional: HAZARD_STALL_CNT_EN adds a saturating count of pc_stall cycles.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_LOAD = 2'd1,
        MD_WAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic br;
    logic br_alu;
    logic br_mload;
    logic do_stall;
    logic do_freeze;
    logic do_flush;
    logic do_halted;

    // Source-operand dependency on a destination; x0 never matches
    assign match_ex  = (bus.ex_rd != REG_W'(0)) &&
                       ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                        (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));
    assign match_mem = (bus.mem_rd != REG_W'(0)) &&
                       ((bus.id_use_rs1 && (bus.mem_rd == bus.id_rs1)) ||
                        (bus.id_use_rs2 && (bus.mem_rd == bus.id_rs2)));

    assign load_use = bus.ex_mem_read && match_ex;
    assign br       = bus.id_branch || bus.id_jump;
    assign br_alu   = br && bus.ex_reg_we && !bus.ex_mem_read && match_ex;
    assign br_mload = br && bus.mem_mem_read && match_mem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next state and stall/freeze/flush decisions
    always_comb begin
        state_nxt = state;
        do_stall  = 1'b0;
        do_freeze = 1'b0;
        do_flush  = 1'b0;
        do_halted = 1'b0;
        case (state)
            RUN: begin
                if (bus.ex_md_start && !bus.md_done) begin
                    do_freeze = 1'b1;
                    state_nxt = MD_WAIT;
                end else if (load_use && br) begin
                    do_stall  = 1'b1;
                    state_nxt = BR_LOAD;
                end else if (load_use || br_alu || br_mload) begin
                    do_stall  = 1'b1;
                end else if (bus.dbg_halt_req) begin
                    state_nxt = HALT;
                end else if (bus.id_redirect) begin
                    do_flush  = 1'b1;
                end
            end
            BR_LOAD: begin
                do_stall  = 1'b1;
                state_nxt = RUN;
            end
            MD_WAIT: begin
                if (bus.md_done) state_nxt = RUN;
                else             do_freeze = 1'b1;
            end
            HALT: begin
                do_freeze = 1'b1;
                do_halted = 1'b1;
                if (!bus.dbg_halt_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Controls are combinational and forced low while reset is held
    assign bus.pc_stall     = !rst && (do_stall || do_freeze);
    assign bus.if_id_stall  = !rst && (do_stall || do_freeze);
    assign bus.id_ex_flush  = !rst && do_stall;
    assign bus.id_ex_stall  = !rst && do_freeze;
    assign bus.ex_mem_flush = !rst && do_freeze;
    assign bus.if_id_flush  = !rst && do_flush;
    assign bus.halted       = !rst && do_halted;
    assign bus.fsm_state    = rst ? RUN : state;

`ifdef HAZARD_STALL_CNT_EN
    localparam int unsigned CNT_W = 32;
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk) begin
        if (rst)                                         stall_cnt <= '0;
        else if (bus.pc_stall && (stall_cnt != '1))     stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign bus.stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected control vectors are hand-derived.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   passed;
    int   failed;
    int   total;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {halted, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, fsm_state}
    function automatic logic [8:0] ov();
        return {bus.halted, bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_flush, bus.fsm_state};
    endfunction

    // Expected vector from STALL/FREEZE/flush/halted flags and state
    function automatic logic [8:0] ev(input logic h, input logic s, input logic f,
                                      input logic fl, input logic [1:0] st);
        return {h, s | f, s | f, fl, f, s, f, st};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

`ifdef HAZARD_STALL_CNT_EN
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
`endif

    task automatic idle();
        bus.id_rs1 = 5'd0;      bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0;  bus.id_use_rs2 = 1'b0;
        bus.id_branch = 1'b0;   bus.id_jump = 1'b0;     bus.id_redirect = 1'b0;
        bus.ex_rd = 5'd0;       bus.ex_reg_we = 1'b0;   bus.ex_mem_read = 1'b0;
        bus.mem_rd = 5'd0;      bus.mem_mem_read = 1'b0;
        bus.ex_md_start = 1'b0; bus.md_done = 1'b0;     bus.dbg_halt_req = 1'b0;
    endtask

    task automatic load_use_r5();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5;      bus.id_use_rs1 = 1'b1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        passed = 0; failed = 0; total = 0;
        rst = 1'b1;
        idle();
        #1 chk("reset_t0", ov(), ev(0, 0, 0, 0, 2'd0));

        // Reset gates a live load-use hazard
        nxt(); load_use_r5();
        #1 chk("reset_gates_outputs", ov(), ev(0, 0, 0, 0, 2'd0));
        nxt(); rst = 1'b0; idle();
        #1 chk("idle_after_reset", ov(), ev(0, 0, 0, 0, 2'd0));
`ifdef HAZARD_STALL_CNT_EN
        chk32("cnt_after_reset", bus.stall_cycles, 32'd0);
`endif

        // Load-use on rs1: one STALL, state stays RUN
        nxt(); load_use_r5();
        #1 chk("load_use_rs1", ov(), ev(0, 1, 0, 0, 2'd0));
        nxt(); idle();
        #1 chk("load_use_clear", ov(), ev(0, 0, 0, 0, 2'd0));

        // Load-use on rs2; unused rs1 match is ignored
        nxt(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd12; bus.id_rs2 = 5'd12; bus.id_use_rs2 = 1'b1;
        #1 chk("load_use_rs2", ov(), ev(0, 1, 0, 0, 2'd0));
        nxt(); idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
        #1 chk("unused_src_no_stall", ov(), ev(0, 0, 0, 0, 2'd0));

        // x0 never hazards
        nxt(); idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        #1 chk("x0_no_stall", ov(), ev(0, 0, 0, 0, 2'd0));

        // Branch after load: 2 STALL cycles, redirect ignored, RUN->BR_LOAD->RUN
        nxt(); idle(); load_use_r5(); bus.id_branch = 1'b1; bus.id_redirect = 1'b1;
        #1 chk("br_load_c0", ov(), ev(0, 1, 0, 0, 2'd0));
        nxt(); bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0;
        #1 chk("br_load_c1", ov(), ev(0, 1, 0, 0, 2'd1));
        nxt();
        #1 chk("br_load_redirect", ov(), ev(0, 0, 0, 1, 2'd0));

        // Branch operand from ALU result in EX
        nxt(); idle(); bus.id_branch = 1'b1; bus.id_redirect = 1'b1;
        bus.ex_reg_we = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
        #1 chk("br_alu", ov(), ev(0, 1, 0, 0, 2'd0));

        // Jump operand from a load in MEM
        nxt(); idle(); bus.id_jump = 1'b1;
        bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
        #1 chk("br_mload", ov(), ev(0, 1, 0, 0, 2'd0));
        nxt(); bus.id_jump = 1'b0;
        #1 chk("mload_non_branch", ov(), ev(0, 0, 0, 0, 2'd0));

        // Mul/div: md_done 4 cycles after start -> 4 FREEZE cycles
        nxt(); idle(); bus.ex_md_start = 1'b1;
        #1 chk("md_c0", ov(), ev(0, 0, 1, 0, 2'd0));
        nxt(); bus.ex_md_start = 1'b0;
        #1 chk("md_c1", ov(), ev(0, 0, 1, 0, 2'd2));
        nxt();
        #1 chk("md_c2", ov(), ev(0, 0, 1, 0, 2'd2));
        nxt();
        #1 chk("md_c3", ov(), ev(0, 0, 1, 0, 2'd2));
        nxt(); bus.md_done = 1'b1;
        #1 chk("md_done", ov(), ev(0, 0, 0, 0, 2'd2));
        nxt(); idle();
        #1 chk("md_back_run", ov(), ev(0, 0, 0, 0, 2'd0));

        // Start and done together: no freeze
        nxt(); bus.ex_md_start = 1'b1; bus.md_done = 1'b1;
        #1 chk("md_same_cycle", ov(), ev(0, 0, 0, 0, 2'd0));
        nxt(); idle();
        #1 chk("md_same_stay_run", ov(), ev(0, 0, 0, 0, 2'd0));

        // Debug halt held 3 cycles; redirect not acted on in the request cycle
        nxt(); bus.dbg_halt_req = 1'b1; bus.id_redirect = 1'b1;
        #1 chk("halt_req", ov(), ev(0, 0, 0, 0, 2'd0));
        nxt(); bus.id_redirect = 1'b0;
        #1 chk("halt_c1", ov(), ev(1, 0, 1, 0, 2'd3));
        nxt();
        #1 chk("halt_c2", ov(), ev(1, 0, 1, 0, 2'd3));
        nxt(); bus.dbg_halt_req = 1'b0;
        #1 chk("halt_release", ov(), ev(1, 0, 1, 0, 2'd3));
        nxt();
        #1 chk("halt_exit", ov(), ev(0, 0, 0, 0, 2'd0));

        // Halt request deferred through MD_WAIT
        nxt(); bus.ex_md_start = 1'b1;
        #1 chk("defer_md_start", ov(), ev(0, 0, 1, 0, 2'd0));
        nxt(); bus.ex_md_start = 1'b0; bus.dbg_halt_req = 1'b1;
        #1 chk("defer_md_wait", ov(), ev(0, 0, 1, 0, 2'd2));
        nxt(); bus.md_done = 1'b1;
        #1 chk("defer_md_done", ov(), ev(0, 0, 0, 0, 2'd2));
        nxt(); bus.md_done = 1'b0;
        #1 chk("defer_run", ov(), ev(0, 0, 0, 0, 2'd0));
        nxt(); bus.dbg_halt_req = 1'b0;
        #1 chk("defer_halted", ov(), ev(1, 0, 1, 0, 2'd3));
        nxt();
        #1 chk("defer_exit", ov(), ev(0, 0, 0, 0, 2'd0));

        // Reset abandons MD_WAIT
        nxt(); bus.ex_md_start = 1'b1;
        #1 chk("rst_md_start", ov(), ev(0, 0, 1, 0, 2'd0));
        nxt(); bus.ex_md_start = 1'b0; rst = 1'b1;
        #1 chk("rst_in_md_wait", ov(), ev(0, 0, 0, 0, 2'd0));
        nxt(); rst = 1'b0;
        #1 chk("rst_md_abandoned", ov(), ev(0, 0, 0, 0, 2'd0));

        // Reset abandons HALT
        nxt(); bus.dbg_halt_req = 1'b1;
        nxt();
        #1 chk("rst_halt_entered", ov(), ev(1, 0, 1, 0, 2'd3));
        nxt(); rst = 1'b1;
        #1 chk("rst_in_halt", ov(), ev(0, 0, 0, 0, 2'd0));
        nxt(); rst = 1'b0; bus.dbg_halt_req = 1'b0;
        #1 chk("rst_halt_abandoned", ov(), ev(0, 0, 0, 0, 2'd0));

        // Six load-use stall cycles after the last reset
        for (int i = 0; i < 6; i++) begin
            nxt(); idle(); load_use_r5();
        end
        nxt(); idle();
        #1 chk("after_six_stalls", ov(), ev(0, 0, 0, 0, 2'd0));
`ifdef HAZARD_STALL_CNT_EN
        chk32("stall_cycles_6", bus.stall_cycles, 32'd6);
`endif

        nxt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
